// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit.
//  - default parameter values, shared with the datapath forward muxes
//  - SEL_RF: select code meaning "read from register file"
//  - act_e: per-edge action chosen by the priority control
package fwd_hazard_scoreboard_pkg;

  localparam int unsigned DEF_NUM_SRC  = 2;
  localparam int unsigned DEF_DEPTH    = 3;
  localparam int unsigned DEF_AW       = 5;
  localparam int unsigned DEF_LOAD_LAT = 1;
  localparam int unsigned DEF_CNT_W    = 16;

  localparam int unsigned SEL_RF = 0;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_FLUSH,
    ACT_HAZARD,
    ACT_ACCEPT,
    ACT_IDLE
  } act_e;

endpackage

// File: rtl/fwd_hazard_scoreboard_match.sv
// fwd_match_prio: compares one source operand against shadow-pipe entries 0..DEPTH-1.
// Ports:
//  rs, rs_used                     source register and its read-enable
//  pipe_valid/pipe_rd/pipe_load    flattened shadow-pipe entries, entry k at [k*AW +: AW]
//  sel_c                           distance of youngest matching writer (0 = regfile)
//  load_hit_c                      youngest match is a load still too close to forward
module fwd_match_prio
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned AW       = DEF_AW,
  parameter  int unsigned LOAD_LAT = DEF_LOAD_LAT,
  localparam int unsigned SELW     = $clog2(DEPTH + 1)
) (
  input  logic [AW-1:0]       rs,
  input  logic                rs_used,
  input  logic [DEPTH-1:0]    pipe_valid,
  input  logic [DEPTH*AW-1:0] pipe_rd,
  input  logic [DEPTH-1:0]    pipe_load,
  output logic [SELW-1:0]     sel_c,
  output logic                load_hit_c
);

  // Scan oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    sel_c      = SELW'(SEL_RF);
    load_hit_c = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (rs_used && pipe_valid[k] && (pipe_rd[k*AW +: AW] == rs)) begin
        sel_c      = SELW'(k + 1);
        load_hit_c = pipe_load[k] && ((k + 1) <= int'(LOAD_LAT));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding + load-use hazard unit between ID and EX.
// Ports:
//  clk, rst_n                 clock, async active-low reset
//  id_valid / id_ready        ID handshake; ready = accepted into EX this cycle
//  id_rs, id_rs_used          source registers (src i at [i*AW +: AW]) and read-enables
//  id_rd, id_we, id_is_load   destination info of the ID instruction
//  stall_ext, flush           downstream freeze / discard ID instruction
//  fwd_sel_ex                 registered per-source forward selects for EX
//  hazard                     load-use stall this cycle
//  stall_cnt                  saturating count of load-use bubbles
module fwd_hazard_scoreboard
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter  int unsigned NUM_SRC  = DEF_NUM_SRC,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned AW       = DEF_AW,
  parameter  int unsigned LOAD_LAT = DEF_LOAD_LAT,
  parameter  int unsigned CNT_W    = DEF_CNT_W,
  localparam int unsigned SELW     = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  output logic                    id_ready,
  input  logic [NUM_SRC*AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]      id_rs_used,
  input  logic [AW-1:0]           id_rd,
  input  logic                    id_we,
  input  logic                    id_is_load,
  input  logic                    stall_ext,
  input  logic                    flush,
  output logic [NUM_SRC*SELW-1:0] fwd_sel_ex,
  output logic                    hazard,
  output logic [CNT_W-1:0]        stall_cnt
);

  // Shadow pipe: entry 0 is the EX occupant, entry k is k stages older.
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH*AW-1:0] rd_q, rd_d;
  logic [DEPTH-1:0]    load_q, load_d;
  logic [NUM_SRC*SELW-1:0] fwd_sel_q, fwd_sel_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC*SELW-1:0] sel_c;
  logic [NUM_SRC-1:0]      load_hit_c;
  act_e                    act_c;

  // One priority matcher per source operand.
  for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_src
    fwd_match_prio #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .LOAD_LAT (LOAD_LAT)
    ) u_match (
      .rs         (id_rs[g*AW +: AW]),
      .rs_used    (id_rs_used[g]),
      .pipe_valid (valid_q),
      .pipe_rd    (rd_q),
      .pipe_load  (load_q),
      .sel_c      (sel_c[g*SELW +: SELW]),
      .load_hit_c (load_hit_c[g])
    );
  end

  assign hazard   = id_valid && !flush && (|load_hit_c);
  assign id_ready = !stall_ext && !hazard && !flush;

  // Edge action: stall_ext > flush > hazard > accept > idle.
  always_comb begin
    act_c = ACT_IDLE;
    if (stall_ext)     act_c = ACT_HOLD;
    else if (flush)    act_c = ACT_FLUSH;
    else if (hazard)   act_c = ACT_HAZARD;
    else if (id_valid) act_c = ACT_ACCEPT;
  end

  // Next state: shift pipe unless frozen, insert ID entry only on accept.
  always_comb begin
    valid_d     = valid_q;
    rd_d        = rd_q;
    load_d      = load_q;
    fwd_sel_d   = fwd_sel_q;
    stall_cnt_d = stall_cnt_q;
    if (act_c != ACT_HOLD) begin
      for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
        valid_d[k]          = valid_q[k-1];
        rd_d[k*AW +: AW]    = rd_q[(k-1)*AW +: AW];
        load_d[k]           = load_q[k-1];
      end
      valid_d[0]    = 1'b0;
      rd_d[0 +: AW] = '0;
      load_d[0]     = 1'b0;
      fwd_sel_d     = '0;
      if (act_c == ACT_ACCEPT) begin
        // x0 writers are stored invalid so they never forward or stall.
        valid_d[0]    = id_we && (id_rd != '0);
        rd_d[0 +: AW] = id_rd;
        load_d[0]     = id_is_load;
        fwd_sel_d     = sel_c;
      end
      if ((act_c == ACT_HAZARD) && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      rd_q        <= '0;
      load_q      <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      load_q      <= load_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_sel_ex = fwd_sel_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Scoreboard bench for fwd_hazard_scoreboard (DEPTH=4, CNT_W=4 to reach distance and saturation limits).
module tb_fwd_hazard_scoreboard;

  localparam int unsigned NS = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned AW = 5;
  localparam int unsigned LL = 1;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = $clog2(D + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_ready, id_we, id_is_load, stall_ext, flush, hazard;
  logic [NS*AW-1:0]  id_rs;
  logic [NS-1:0]     id_rs_used;
  logic [AW-1:0]     id_rd;
  logic [NS*SW-1:0]  fwd_sel_ex;
  logic [CW-1:0]     stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard #(
    .NUM_SRC(NS), .DEPTH(D), .AW(AW), .LOAD_LAT(LL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .stall_ext(stall_ext), .flush(flush),
    .fwd_sel_ex(fwd_sel_ex), .hazard(hazard), .stall_cnt(stall_cnt)
  );

  typedef struct packed { logic w; logic [AW-1:0] rd; logic ld; } ent_t;
  typedef struct packed { logic haz; logic rdy; } comb_t;
  typedef struct packed { logic [NS*SW-1:0] sel; logic [CW-1:0] cnt; } seq_t;

  // Reference: history of what entered EX, index 0 = most recent (distance 1 for the ID instruction).
  ent_t  hist[$];
  comb_t q_comb[$];
  seq_t  q_seq[$];
  logic [NS*SW-1:0] m_sel;
  logic [CW-1:0]    m_cnt;
  logic             last_acc, last_fl, last_sx;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int dist_of(input logic [AW-1:0] r);
    for (int k = 0; k < hist.size() && k < int'(D); k++)
      if (hist[k].w && hist[k].rd == r) return k + 1;
    return 0;
  endfunction

  function automatic logic too_close(input int d);
    if (d == 0) return 1'b0;
    return hist[d-1].ld && (d <= int'(LL));
  endfunction

  task automatic model_reset();
    hist.delete(); q_comb.delete(); q_seq.delete();
    m_sel = '0; m_cnt = '0;
    last_acc = 1'b0; last_fl = 1'b0; last_sx = 1'b0;
  endtask

  // Drive one ID cycle at posedge+1, record expectations, advance the model to the next edge.
  task automatic cyc(input logic v, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                     input logic [1:0] u, input logic [AW-1:0] rd, input logic we,
                     input logic ld, input logic sx, input logic fl);
    int d0, d1;
    logic haz, rdy;
    ent_t e;
    id_valid = v; id_rs = {r1, r0}; id_rs_used = u; id_rd = rd;
    id_we = we; id_is_load = ld; stall_ext = sx; flush = fl;
    q_seq.push_back('{sel: m_sel, cnt: m_cnt});
    d0 = u[0] ? dist_of(r0) : 0;
    d1 = u[1] ? dist_of(r1) : 0;
    haz = v && !fl && (too_close(d0) || too_close(d1));
    rdy = !sx && !haz && !fl;
    q_comb.push_back('{haz: haz, rdy: rdy});
    last_acc = v && rdy; last_fl = fl; last_sx = sx;
    if (!sx) begin
      e = '0;
      m_sel = '0;
      if (rdy && v) begin
        e = '{w: we && (rd != '0), rd: rd, ld: ld};
        m_sel = {SW'(d1), SW'(d0)};
      end
      if (haz && !fl && m_cnt != '1) m_cnt = m_cnt + CW'(1);
      hist.push_front(e);
      if (hist.size() > int'(D)) void'(hist.pop_back());
    end
    @(posedge clk); #1;
  endtask

  // Present an instruction until ID hands it over (bounded).
  task automatic issue(input logic [AW-1:0] rd, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic [1:0] u, input logic we, input logic ld);
    int tries = 0;
    do begin
      cyc(1'b1, r0, r1, u, rd, we, ld, 1'b0, 1'b0);
      tries++;
    end while (!last_acc && tries < 6);
    chk("issue_accepted", 32'(last_acc), 32'd1);
  endtask

  task automatic nop();
    cyc(1'b0, '0, '0, 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    comb_t c;
    seq_t  s;
    if (rst_n) begin
      if (q_comb.size() > 0) begin
        c = q_comb.pop_front();
        chk("hazard", 32'(hazard), 32'(c.haz));
        chk("id_ready", 32'(id_ready), 32'(c.rdy));
      end
      if (q_seq.size() > 0) begin
        s = q_seq.pop_front();
        chk("fwd_sel_ex", 32'(fwd_sel_ex), 32'(s.sel));
        chk("stall_cnt", 32'(stall_cnt), 32'(s.cnt));
      end
    end
  end

  initial begin
    logic [AW-1:0] rr0, rr1, rrd;
    logic [1:0]    ru;
    logic          rwe, rld, rv, rsx, rfl;

    rst_n = 1'b0;
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_we = 0; id_is_load = 0; stall_ext = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_sel", 32'(fwd_sel_ex), 32'd0);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_hazard", 32'(hazard), 32'd0);
    @(posedge clk); #1;

    // Back-to-back ALU dependency
    issue(5'd5, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0);
    issue(5'd6, 5'd5, 5'd5, 2'b11, 1'b1, 1'b0);
    chk("alu_fwd_sel", 32'(fwd_sel_ex), 32'({SW'(1), SW'(1)}));
    // Load-use: one bubble, then distance 2
    issue(5'd5, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);
    issue(5'd6, 5'd5, 5'd1, 2'b11, 1'b1, 1'b0);
    chk("lu_fwd_sel", 32'(fwd_sel_ex), 32'({SW'(0), SW'(2)}));
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    // x0 never forwards or stalls
    issue(5'd0, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0);
    issue(5'd7, 5'd0, 5'd0, 2'b11, 1'b1, 1'b0);
    issue(5'd0, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);
    issue(5'd8, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0);
    // Youngest wins, then distance limits
    issue(5'd7, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0);
    issue(5'd7, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0);
    issue(5'd9, 5'd7, 5'd0, 2'b11, 1'b1, 1'b0);
    issue(5'd10, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0);
    repeat (3) nop();
    issue(5'd11, 5'd10, 5'd0, 2'b01, 1'b1, 1'b0);
    chk("dist4_sel", 32'(fwd_sel_ex), 32'({SW'(0), SW'(4)}));
    issue(5'd12, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0);
    repeat (4) nop();
    issue(5'd13, 5'd12, 5'd0, 2'b01, 1'b1, 1'b0);
    chk("dist5_sel", 32'(fwd_sel_ex), 32'd0);
    // stall_ext freeze over a pending load-use
    issue(5'd5, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);
    repeat (3) cyc(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(5'd6, 5'd5, 5'd1, 2'b11, 1'b1, 1'b0);
    // flush over a pending load-use
    issue(5'd5, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);
    cyc(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(5'd6, 5'd5, 5'd1, 2'b11, 1'b1, 1'b0);
    // Saturation of the bubble counter
    for (int i = 0; i < 20; i++) begin
      issue(5'd5, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);
      issue(5'd6, 5'd5, 5'd5, 2'b11, 1'b1, 1'b0);
    end
    chk("cnt_saturated", 32'(stall_cnt), 32'd15);

    // Async reset while a hazard is showing
    issue(5'd5, 5'd1, 5'd0, 2'b01, 1'b1, 1'b1);
    id_valid = 1; id_rs = {5'd1, 5'd5}; id_rs_used = 2'b11; id_rd = 5'd6;
    id_we = 1; id_is_load = 0; stall_ext = 0; flush = 0;
    #1 chk("pre_reset_hazard", 32'(hazard), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_hazard", 32'(hazard), 32'd0);
    chk("async_rst_sel", 32'(fwd_sel_ex), 32'd0);
    chk("async_rst_cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    id_valid = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(5'd6, 5'd5, 5'd1, 2'b11, 1'b1, 1'b0);
    chk("post_reset_sel", 32'(fwd_sel_ex), 32'd0);

    // Randomized traffic; a held instruction is re-presented until accepted or flushed
    rv = 1; rr0 = 1; rr1 = 2; ru = 2'b11; rrd = 3; rwe = 1; rld = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 0 || last_acc || (last_fl && !last_sx) || !rv) begin
        rv  = ($urandom_range(7) != 0);
        rr0 = AW'($urandom_range(7));
        rr1 = AW'($urandom_range(7));
        ru  = 2'($urandom_range(3));
        rrd = AW'($urandom_range(7));
        rwe = ($urandom_range(3) != 0);
        rld = ($urandom_range(2) == 0);
      end
      rsx = ($urandom_range(7) == 0);
      rfl = ($urandom_range(9) == 0);
      cyc(rv, rr0, rr1, ru, rrd, rwe, rld, rsx, rfl);
    end
    nop();
    chk("queues_drained", 32'(q_comb.size() + q_seq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
